// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, memory DM_W codes
// and the sequencer state type.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [1:0] DMW_READ = 2'b00;
    localparam logic [1:0] DMW_WORD = 2'b01;
    localparam logic [1:0] DMW_HALF = 2'b10;
    localparam logic [1:0] DMW_BYTE = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    // Memory write-strobe code for a store of the given size.
    function automatic logic [1:0] dmw_for_size(input logic [1:0] size);
        case (size)
            SZ_WORD: dmw_for_size = DMW_WORD;
            SZ_HALF: dmw_for_size = DMW_HALF;
            SZ_BYTE: dmw_for_size = DMW_BYTE;
            default: dmw_for_size = DMW_READ;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Sizes raw memory read data to byte/half/word and applies sign or zero extension.
module dmem_load_ext
    import dmem_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = raw_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{sign_i & raw_i[7]}}, raw_i[7:0]};
            SZ_HALF: data_o = {{16{sign_i & raw_i[15]}}, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and IDLE/ACCESS/DONE sequencer in front of the
// byte-addressed data memory; every output is a register.
module dmem_arbiter
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              r0_req_i,
    input  logic              r0_we_i,
    input  logic [1:0]        r0_size_i,
    input  logic              r0_sign_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [31:0]       r0_wdata_i,
    output logic              r0_gnt_o,
    output logic              r0_done_o,
    output logic              r0_err_o,
    output logic [31:0]       r0_rdata_o,

    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [1:0]        r1_size_i,
    input  logic              r1_sign_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [31:0]       r1_wdata_i,
    output logic              r1_gnt_o,
    output logic              r1_done_o,
    output logic              r1_err_o,
    output logic [31:0]       r1_rdata_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [1:0]        mem_dm_w_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
    localparam logic [ADDR_W-1:0] WORD_MAX = ADDR_TOP - ADDR_W'(3);

    state_e            state_q;
    logic              ptr_q;
    logic              win_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic              err_q;
    logic [1:0]        gnt_q;
    logic [1:0]        done_q;
    logic [1:0]        perr_q;
    logic [31:0]       r0_rdata_q;
    logic [31:0]       r1_rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [1:0]        mem_dm_w_q;

    logic              pick1;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_sign;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              sel_err;
    logic [31:0]       ext_data;

    // On a tie the port that was not granted last wins; ptr_q holds the last winner.
    always_comb begin
        if (r0_req_i && r1_req_i) begin
            pick1 = ~ptr_q;
        end else begin
            pick1 = r1_req_i;
        end
        sel_we    = pick1 ? r1_we_i    : r0_we_i;
        sel_size  = pick1 ? r1_size_i  : r0_size_i;
        sel_sign  = pick1 ? r1_sign_i  : r0_sign_i;
        sel_addr  = pick1 ? r1_addr_i  : r0_addr_i;
        sel_wdata = pick1 ? r1_wdata_i : r0_wdata_i;
        sel_err   = (sel_size == SZ_RSVD) ||
                    ((sel_size == SZ_WORD) && (sel_addr > WORD_MAX)) ||
                    ((sel_size == SZ_HALF) && (sel_addr == ADDR_TOP));
    end

    dmem_load_ext u_load_ext (
        .size_i (size_q),
        .sign_i (sign_q),
        .raw_i  (mem_rdata_i),
        .data_o (ext_data)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b1;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            perr_q      <= 2'b00;
            r0_rdata_q  <= '0;
            r1_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_dm_w_q  <= DMW_READ;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r0_req_i || r1_req_i) begin
                        ptr_q       <= pick1;
                        win_q       <= pick1;
                        we_q        <= sel_we;
                        size_q      <= sel_size;
                        sign_q      <= sel_sign;
                        err_q       <= sel_err;
                        gnt_q       <= {pick1, ~pick1};
                        mem_addr_q  <= sel_addr;
                        mem_wdata_q <= sel_we ? sel_wdata : '0;
                        // A rejected store still spends ACCESS, but with no strobe.
                        mem_dm_w_q  <= (sel_we && !sel_err) ? dmw_for_size(sel_size)
                                                            : DMW_READ;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt_q       <= 2'b00;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_dm_w_q  <= DMW_READ;
                    done_q      <= {win_q, ~win_q};
                    perr_q      <= {win_q & err_q, ~win_q & err_q};
                    if (win_q) begin
                        r1_rdata_q <= (err_q || we_q) ? '0 : ext_data;
                    end else begin
                        r0_rdata_q <= (err_q || we_q) ? '0 : ext_data;
                    end
                    state_q     <= DONE;
                end
                DONE: begin
                    done_q     <= 2'b00;
                    perr_q     <= 2'b00;
                    r0_rdata_q <= '0;
                    r1_rdata_q <= '0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r0_gnt_o    = gnt_q[0];
    assign r1_gnt_o    = gnt_q[1];
    assign r0_done_o   = done_q[0];
    assign r1_done_o   = done_q[1];
    assign r0_err_o    = perr_q[0];
    assign r1_err_o    = perr_q[1];
    assign r0_rdata_o  = r0_rdata_q;
    assign r1_rdata_o  = r1_rdata_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_dm_w_o  = mem_dm_w_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a negedge-clocked byte memory model.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_req, r0_we, r0_sign, r0_gnt, r0_done, r0_err;
    logic [1:0]  r0_size;
    logic [7:0]  r0_addr;
    logic [31:0] r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_sign, r1_gnt, r1_done, r1_err;
    logic [1:0]  r1_size;
    logic [7:0]  r1_addr;
    logic [31:0] r1_wdata, r1_rdata;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [1:0]  mem_dm_w;

    logic [7:0]  mem [256];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [1:0]  size;
        logic        sign;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [17];

    dmem_arbiter #(.ADDR_W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .r0_req_i    (r0_req),
        .r0_we_i     (r0_we),
        .r0_size_i   (r0_size),
        .r0_sign_i   (r0_sign),
        .r0_addr_i   (r0_addr),
        .r0_wdata_i  (r0_wdata),
        .r0_gnt_o    (r0_gnt),
        .r0_done_o   (r0_done),
        .r0_err_o    (r0_err),
        .r0_rdata_o  (r0_rdata),
        .r1_req_i    (r1_req),
        .r1_we_i     (r1_we),
        .r1_size_i   (r1_size),
        .r1_sign_i   (r1_sign),
        .r1_addr_i   (r1_addr),
        .r1_wdata_i  (r1_wdata),
        .r1_gnt_o    (r1_gnt),
        .r1_done_o   (r1_done),
        .r1_err_o    (r1_err),
        .r1_rdata_o  (r1_rdata),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_dm_w_o  (mem_dm_w),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: writes and reads happen on the falling edge inside the access cycle.
    always @(negedge clk) begin
        case (mem_dm_w)
            2'b01: begin
                mem[mem_addr]        <= mem_wdata[7:0];
                mem[mem_addr + 8'd1] <= mem_wdata[15:8];
                mem[mem_addr + 8'd2] <= mem_wdata[23:16];
                mem[mem_addr + 8'd3] <= mem_wdata[31:24];
            end
            2'b10: begin
                mem[mem_addr]        <= mem_wdata[7:0];
                mem[mem_addr + 8'd1] <= mem_wdata[15:8];
            end
            2'b11: mem[mem_addr] <= mem_wdata[7:0];
            default: ;
        endcase
        mem_rdata <= {mem[mem_addr + 8'd3], mem[mem_addr + 8'd2],
                      mem[mem_addr + 8'd1], mem[mem_addr]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_dmw(input logic we, input logic [1:0] size,
                                            input logic err);
        if (!we || err) return 2'b00;
        case (size)
            2'b10:   return 2'b01;
            2'b01:   return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic drive(input vec_t v, input logic req);
        if (v.port) begin
            r1_req = req; r1_we = v.we; r1_size = v.size; r1_sign = v.sign;
            r1_addr = v.addr; r1_wdata = v.wdata;
        end else begin
            r0_req = req; r0_we = v.we; r0_size = v.size; r0_sign = v.sign;
            r0_addr = v.addr; r0_wdata = v.wdata;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int   n;
        logic got;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        drive(v, 1'b1);
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            got = v.port ? r1_gnt : r0_gnt;
            n++;
        end
        check({tag, "_gnt"}, {31'd0, got}, 32'd1);
        if (got) begin
            check({tag, "_gnt_other"}, {31'd0, v.port ? r0_gnt : r1_gnt}, 32'd0);
            check({tag, "_dmw_access"}, {30'd0, mem_dm_w}, {30'd0, exp_dmw(v.we, v.size, v.exp_err)});
            check({tag, "_mem_addr"}, {24'd0, mem_addr}, {24'd0, v.addr});
            if (v.we && !v.exp_err) check({tag, "_mem_wdata"}, mem_wdata, v.wdata);
            @(posedge clk); #1;
            drive(v, 1'b0);
            @(negedge clk);
            check({tag, "_done"}, {31'd0, v.port ? r1_done : r0_done}, 32'd1);
            check({tag, "_done_other"}, {31'd0, v.port ? r0_done : r1_done}, 32'd0);
            check({tag, "_err"}, {31'd0, v.port ? r1_err : r0_err}, {31'd0, v.exp_err});
            check({tag, "_rdata"}, v.port ? r1_rdata : r0_rdata, v.exp_rdata);
            check({tag, "_dmw_done"}, {30'd0, mem_dm_w}, 32'd0);
            @(negedge clk);
            check({tag, "_done_pulse"}, {31'd0, v.port ? r1_done : r0_done}, 32'd0);
        end else begin
            drive(v, 1'b0);
        end
    endtask

    initial begin
        int   k, dones, n;
        logic last, got;
        logic [1:0] order [4];

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem_rdata = '0;
        r0_req = 0; r0_we = 0; r0_size = 0; r0_sign = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_size = 0; r1_sign = 0; r1_addr = 0; r1_wdata = 0;

        //           port we  size sign addr   wdata          exp_rdata      err
        vecs[0]  = '{1'b0, 1, 2'b10, 0, 8'h10, 32'hA1B2C3D4, 32'h0,         0};
        vecs[1]  = '{1'b0, 0, 2'b10, 0, 8'h10, 32'h0,        32'hA1B2C3D4, 0};
        vecs[2]  = '{1'b0, 1, 2'b00, 0, 8'h20, 32'h00000080, 32'h0,         0};
        vecs[3]  = '{1'b0, 0, 2'b00, 1, 8'h20, 32'h0,        32'hFFFFFF80, 0};
        vecs[4]  = '{1'b0, 0, 2'b00, 0, 8'h20, 32'h0,        32'h00000080, 0};
        vecs[5]  = '{1'b1, 1, 2'b01, 0, 8'h21, 32'h00008001, 32'h0,         0};
        vecs[6]  = '{1'b1, 0, 2'b01, 1, 8'h21, 32'h0,        32'hFFFF8001, 0};
        vecs[7]  = '{1'b0, 0, 2'b10, 0, 8'h20, 32'h0,        32'h00800180, 0};
        vecs[8]  = '{1'b1, 1, 2'b10, 0, 8'hFC, 32'h11223344, 32'h0,         0};
        vecs[9]  = '{1'b0, 1, 2'b10, 0, 8'h00, 32'hCAFEF00D, 32'h0,         0};
        vecs[10] = '{1'b0, 1, 2'b10, 0, 8'hFD, 32'hDEADBEEF, 32'h0,         1};
        vecs[11] = '{1'b1, 1, 2'b11, 0, 8'h00, 32'h55555555, 32'h0,         1};
        vecs[12] = '{1'b0, 0, 2'b01, 0, 8'hFF, 32'h0,        32'h0,         1};
        vecs[13] = '{1'b1, 0, 2'b10, 0, 8'hFC, 32'h0,        32'h11223344, 0};
        vecs[14] = '{1'b0, 0, 2'b10, 0, 8'h00, 32'h0,        32'hCAFEF00D, 0};
        vecs[15] = '{1'b1, 0, 2'b00, 0, 8'hFF, 32'h0,        32'h00000011, 0};
        vecs[16] = '{1'b0, 0, 2'b01, 0, 8'hFE, 32'h0,        32'h00001122, 0};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", {30'd0, r1_gnt, r0_gnt}, 32'd0);
        check("rst_done", {30'd0, r1_done, r0_done}, 32'd0);
        check("rst_err", {30'd0, r1_err, r0_err}, 32'd0);
        check("rst_rdata", r0_rdata | r1_rdata, 32'd0);
        check("rst_dmw", {30'd0, mem_dm_w}, 32'd0);
        check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Clean reset so the first tie goes to port 0.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        r0_req = 1; r0_we = 0; r0_size = 2'b10; r0_sign = 0; r0_addr = 8'h10;
        r1_req = 1; r1_we = 0; r1_size = 2'b10; r1_sign = 0; r1_addr = 8'h00;
        k = 0; dones = 0; last = 1'b0; n = 0;
        while (dones < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (r0_gnt || r1_gnt) begin
                check("arb_gnt_onehot", {30'd0, r1_gnt, r0_gnt} & 32'd3,
                      (k % 2 == 0) ? 32'd1 : 32'd2);
                last = r1_gnt;
                if (k < 4) order[k] = {1'b0, r1_gnt};
                k++;
                if (k == 4) begin
                    r0_req = 0;
                    r1_req = 0;
                end
            end
            if (r0_done || r1_done) begin
                dones++;
                check("arb_done_port", {30'd0, r1_done, r0_done}, last ? 32'd2 : 32'd1);
                if (r0_done) check("arb_r0_rdata", r0_rdata, 32'hA1B2C3D4);
                if (r1_done) check("arb_r1_rdata", r1_rdata, 32'hCAFEF00D);
            end
        end
        r0_req = 0; r1_req = 0;
        check("arb_grants", k, 4);
        check("arb_dones", dones, 4);
        if (k >= 4) check("arb_order", {24'd0, order[0][0], order[1][0], order[2][0], order[3][0]},
                          32'h5);

        // Reset in the ACCESS cycle of a word store must squash the write.
        run_vec('{1'b0, 1, 2'b10, 0, 8'h40, 32'h01020304, 32'h0, 0}, 100);
        @(posedge clk); #1;
        r0_req = 1; r0_we = 1; r0_size = 2'b10; r0_addr = 8'h40; r0_wdata = 32'hFFFFFFFF;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            got = r0_gnt;
            n++;
        end
        check("rstmid_gnt", {31'd0, got}, 32'd1);
        rst_n = 1'b0;
        r0_req = 0;
        #1;
        check("rstmid_dmw", {30'd0, mem_dm_w}, 32'd0);
        check("rstmid_gnt_clr", {31'd0, r0_gnt}, 32'd0);
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (r0_done || r1_done) dones++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (r0_done || r1_done) dones++;
        end
        check("rstmid_no_done", dones, 0);
        check("rstmid_idle", {30'd0, dut.state_q}, {30'd0, dmem_ctrl_pkg::IDLE});
        check("rstmid_mem", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 32'h01020304);
        run_vec('{1'b1, 0, 2'b10, 0, 8'h40, 32'h0, 32'h01020304, 0}, 101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
